chan_seq: RTL and testbench
===========================

// Module: chan_seq
// PURPOSE
//  Parametrised successor of the sound DMA channel controller. Once per frame (sync_stb), scans NUM_CH channels.
//  For each enabled channel: fetches 4 state words from channel RAM, streams sample address + volumes to mixer,
//  advances a fixed-point position by a per-channel step, handles end-of-sample, writes the position back.
// PARAMETERS
//  NUM_CH  32  channel count, power of 2, 2..64
//  CH_AW   $clog2(NUM_CH)  channel index width (derived, do not override)
//  ADDR_W  22  integer sample-address bits; FRAC_W = 32-ADDR_W fraction bits (default 10)
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous reset, active high
//  rd_addr       out  CH_AW+2  channel RAM read address {ch, word}
//  rd_data       in   32       channel RAM read data, valid 1 clk after rd_addr
//  wr_addr       out  CH_AW+2  channel RAM write address
//  wr_data       out  32       channel RAM write data
//  wr_stb        out  1        write strobe, 1 clk
//  sync_stb      in   1        frame start, 1-clk pulse
//  ch_enas       in   NUM_CH   per-channel enable
//  out_data      out  8        byte to mixer
//  out_stb_addr  out  1        out_data is a sample-address byte
//  out_stb_mix   out  1        out_data is a volume byte
//  done_stb      out  1        channel reached end (one-shot), 1 clk
//  done_ch       out  CH_AW    channel index for done_stb
//  busy          out  1        frame in progress
//  overrun       out  1        sticky: sync_stb arrived while busy; cleared only by rst
// BEHAVIOUR
//  Word map per channel (base ch*4): W0 pos = {addr[ADDR_W-1:0], frac[FRAC_W-1:0]};
//   W1 = {vol_r[7:0], vol_l[7:0], step[15:0]} (step: 6.10 fixed point, zero-extended to 32 for add);
//   W2 = end_addr in [ADDR_W-1:0]; W3 = {loop_en[31], loop_addr in [ADDR_W-1:0]}.
//  Reset: all outputs 0, FSM IDLE, pending and overrun cleared. Reset mid-frame aborts the frame; no wr_stb is issued.
//  IDLE: on sync_stb, latch ch_enas, ch=0, busy=1 -> SCAN.
//  SCAN: 1 clk per channel. Disabled -> ch+1; enabled -> RD. After ch NUM_CH-1 -> IDLE, busy=0.
//  RD: rd_addr = {ch,0..3} on 4 consecutive clks -> WAIT (1 clk, W3 data arrives).
//  EMIT: 5 clks; out_data = addr[23:16], [15:8], [7:0] with out_stb_addr (address zero-padded to 24 bits),
//   then vol_l, vol_r with out_stb_mix. Exactly one strobe per clk; out_data is 0 when no strobe.
//  WB: sum = pos + step, 33 bits. hit_end = carry | (sum[31:FRAC_W] > end_addr).
//   No hit_end: wr W0 = sum[31:0]. On hit_end: see CONFIGURATION. Single wr_stb at {ch,0}. Then ch+1 -> SCAN.
//  Enabled channel = 11 clks + 1 SCAN clk; 32 channels all enabled = 384 clks (fits 640-clk frame).
//  sync_stb while busy: set overrun, set pending; on frame completion restart immediately from ch 0.
//   Multiple syncs while busy collapse into one pending.
//  sync_stb in the same clk the frame completes: treated as pending, no overrun.
//  ch_enas changes mid-frame are ignored until the next frame latch.
//  step=0: position unchanged, W0 still written back.
// CONFIGURATION
//  CHAN_SEQ_LOOP_EN defined: on hit_end with W3[31]=1, W0 = {loop_addr, sum[FRAC_W-1:0]}, no done_stb;
//   with W3[31]=0, one-shot behaviour as below.
//  CHAN_SEQ_LOOP_EN undefined: W3[31] is ignored; hit_end always one-shot: W0 = {end_addr, FRAC_W'b0},
//   done_stb=1 and done_ch=ch in the WB clk.
// STRUCTURE
//  chan_seq_pkg: word offsets (W_POS, W_CTL, W_END, W_LOOP), field bit ranges, FSM state encoding.
//  chan_seq_step submodule: combinational pos/step/end/loop -> new_pos, hit_end. Instantiated once.
// TESTING
//  1. One channel enabled (ch 5): pos=0x00001000, step=0x0400, end=0x100.
//     -> bytes 00,00,04 + vol_l, vol_r; W0 written 0x00001400 at addr {5,0}.
//  2. All ch_enas=0, sync_stb -> busy for 32 clks; no rd/wr/out strobes; busy falls.
//  3. pos addr=end_addr, step=0x0400, loop_en=1, loop=0x10, with LOOP_EN
//     -> W0={0x10, frac}, no done_stb; without LOOP_EN -> W0={end,0}, done_stb, done_ch=ch.
//  4. All 32 enabled, sync_stb every 300 clks -> overrun=1, frames restart back-to-back; no lost/duplicate wr_stb.
//  5. Assert rst during EMIT of ch 3 -> next clk all outputs 0, no wr_stb for ch 3; next sync_stb restarts at ch 0.
//  6. pos=0xFFFFFFFF, step=1 -> carry sets hit_end; one-shot writes {end_addr,0}.

Source files
------------

// File: rtl/chan_seq_pkg.sv
// Shared definitions for the per-frame channel sequencer: channel RAM word map,
// control-word layout and FSM encoding.
package chan_seq_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STEP_W   = 16;
    localparam int unsigned VOL_W    = 8;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned OUT_AW   = 24;
    localparam int unsigned RD_LEN   = 4;
    localparam int unsigned EMIT_LEN = 5;
    localparam int unsigned CNT_W    = 3;

    // Word offsets inside a channel's 4-word RAM slot
    localparam logic [1:0] W_POS  = 2'd0;
    localparam logic [1:0] W_CTL  = 2'd1;
    localparam logic [1:0] W_END  = 2'd2;
    localparam logic [1:0] W_LOOP = 2'd3;

    localparam int unsigned LOOP_EN_BIT = 31;

    typedef struct packed {
        logic [VOL_W-1:0]  vol_r;
        logic [VOL_W-1:0]  vol_l;
        logic [STEP_W-1:0] step;
    } ctl_word_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_EMIT = 3'd4,
        S_WB   = 3'd5
    } state_t;

endpackage

// File: rtl/chan_seq_if.sv
// Channel RAM, frame control and mixer-side signals of chan_seq.
interface chan_seq_if
    import chan_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 32
);
    localparam int unsigned CH_AW = $clog2(NUM_CH);

    logic [CH_AW+1:0]  rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [CH_AW+1:0]  wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_stb;
    logic              sync_stb;
    logic [NUM_CH-1:0] ch_enas;
    logic [BYTE_W-1:0] out_data;
    logic              out_stb_addr;
    logic              out_stb_mix;
    logic              done_stb;
    logic [CH_AW-1:0]  done_ch;
    logic              busy;
    logic              overrun;

    modport master (
        output rd_addr, wr_addr, wr_data, wr_stb, out_data, out_stb_addr,
               out_stb_mix, done_stb, done_ch, busy, overrun,
        input  rd_data, sync_stb, ch_enas
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_stb, out_data, out_stb_addr,
               out_stb_mix, done_stb, done_ch, busy, overrun,
        output rd_data, sync_stb, ch_enas
    );

endinterface

// File: rtl/chan_seq_step.sv
// Position advance: pos + step with end-of-sample detection.
// CHAN_SEQ_LOOP_EN enables wrap to the loop address instead of one-shot stop.
module chan_seq_step
    import chan_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 22
) (
    input  logic [WORD_W-1:0] pos,
    input  logic [STEP_W-1:0] step,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] loop_addr,
    output logic [WORD_W-1:0] new_pos,
    output logic              hit_end,
    output logic              done
);
    localparam int unsigned FRAC_W = WORD_W - ADDR_W;

    logic [WORD_W:0] sum;

    always_comb begin
        sum     = {1'b0, pos} + (WORD_W + 1)'(step);
        hit_end = sum[WORD_W] | (sum[WORD_W-1:FRAC_W] > end_addr);
        new_pos = sum[WORD_W-1:0];
        done    = 1'b0;
`ifdef CHAN_SEQ_LOOP_EN
        if (hit_end && loop_en) begin
            new_pos = {loop_addr, sum[FRAC_W-1:0]};
        end else if (hit_end) begin
            new_pos = {end_addr, FRAC_W'(0)};
            done    = 1'b1;
        end
`else
        if (hit_end) begin
            new_pos = {end_addr, FRAC_W'(0)};
            done    = 1'b1;
        end
`endif
    end

`ifndef CHAN_SEQ_LOOP_EN
    // Loop fields only matter when looping is built in
    logic unused_loop;
    assign unused_loop = ^{loop_en, loop_addr};
`endif

endmodule

// File: rtl/chan_seq.sv
// Per-frame channel sequencer: fetch channel state, stream address/volume bytes
// to the mixer, advance and write back the position. Optional CHAN_SEQ_LOOP_EN.
module chan_seq
    import chan_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned ADDR_W = 22
) (
    input logic       clk,
    input logic       rst,
    chan_seq_if.master bus
);
    localparam int unsigned CH_AW  = $clog2(NUM_CH);
    localparam int unsigned FRAC_W = WORD_W - ADDR_W;

    state_t            state, state_n;
    logic [CH_AW-1:0]  ch, ch_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NUM_CH-1:0] ena, ena_n;
    logic              pending, pending_n;
    logic              overrun_q, overrun_n;
    logic              frame_end;

    logic [CH_AW+1:0]  rd_addr_q, rd_addr_n;
    logic [CH_AW+1:0]  wr_addr_q, wr_addr_n;
    logic [WORD_W-1:0] wr_data_q, wr_data_n;
    logic              wr_stb_q, wr_stb_n;
    logic [BYTE_W-1:0] out_data_q, out_data_n;
    logic              out_stb_addr_q, out_stb_addr_n;
    logic              out_stb_mix_q, out_stb_mix_n;
    logic              done_stb_q, done_stb_n;
    logic [CH_AW-1:0]  done_ch_q, done_ch_n;
    logic              busy_q, busy_n;

    logic [WORD_W-1:0] w_pos, w_end, w_loop;
    ctl_word_t         w_ctl;
    logic [OUT_AW-1:0] addr24;

    logic [WORD_W-1:0] new_pos;
    logic              hit_end, step_done;

    chan_seq_step #(.ADDR_W(ADDR_W)) u_step (
        .pos       (w_pos),
        .step      (w_ctl.step),
        .end_addr  (w_end[ADDR_W-1:0]),
        .loop_en   (w_loop[LOOP_EN_BIT]),
        .loop_addr (w_loop[ADDR_W-1:0]),
        .new_pos   (new_pos),
        .hit_end   (hit_end),
        .done      (step_done)
    );

    logic unused_bits;
    assign unused_bits = ^{w_end, w_loop, hit_end};

    // Channel words arrive one clk after their address was presented
    always_ff @(posedge clk) begin
        if (rst) begin
            w_pos  <= '0;
            w_ctl  <= '0;
            w_end  <= '0;
            w_loop <= '0;
        end else begin
            if (state == S_RD) begin
                case (cnt)
                    3'd1:    w_pos <= bus.rd_data;
                    3'd2:    w_ctl <= bus.rd_data;
                    3'd3:    w_end <= bus.rd_data;
                    default: ;
                endcase
            end
            if (state == S_WAIT) w_loop <= bus.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ch             <= '0;
            cnt            <= '0;
            ena            <= '0;
            pending        <= 1'b0;
            overrun_q      <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_stb_q       <= 1'b0;
            out_data_q     <= '0;
            out_stb_addr_q <= 1'b0;
            out_stb_mix_q  <= 1'b0;
            done_stb_q     <= 1'b0;
            done_ch_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            state          <= state_n;
            ch             <= ch_n;
            cnt            <= cnt_n;
            ena            <= ena_n;
            pending        <= pending_n;
            overrun_q      <= overrun_n;
            rd_addr_q      <= rd_addr_n;
            wr_addr_q      <= wr_addr_n;
            wr_data_q      <= wr_data_n;
            wr_stb_q       <= wr_stb_n;
            out_data_q     <= out_data_n;
            out_stb_addr_q <= out_stb_addr_n;
            out_stb_mix_q  <= out_stb_mix_n;
            done_stb_q     <= done_stb_n;
            done_ch_q      <= done_ch_n;
            busy_q         <= busy_n;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n        = state;
        ch_n           = ch;
        cnt_n          = cnt;
        ena_n          = ena;
        pending_n      = pending;
        overrun_n      = overrun_q;
        frame_end      = 1'b0;
        rd_addr_n      = '0;
        wr_addr_n      = '0;
        wr_data_n      = '0;
        wr_stb_n       = 1'b0;
        out_data_n     = '0;
        out_stb_addr_n = 1'b0;
        out_stb_mix_n  = 1'b0;
        done_stb_n     = 1'b0;
        done_ch_n      = '0;
        addr24         = OUT_AW'(w_pos[WORD_W-1:FRAC_W]);

        unique case (state)
            S_IDLE: begin
                if (bus.sync_stb) begin
                    ena_n   = bus.ch_enas;
                    ch_n    = '0;
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ena[ch]) begin
                    state_n   = S_RD;
                    cnt_n     = '0;
                    rd_addr_n = {ch, W_POS};
                end else if (ch == CH_AW'(NUM_CH - 1)) begin
                    frame_end = 1'b1;
                end else begin
                    ch_n = ch + CH_AW'(1);
                end
            end
            S_RD: begin
                if (cnt == CNT_W'(RD_LEN - 1)) begin
                    state_n = S_WAIT;
                end else begin
                    cnt_n     = cnt + CNT_W'(1);
                    rd_addr_n = {ch, cnt_n[1:0]};
                end
            end
            S_WAIT: begin
                state_n        = S_EMIT;
                cnt_n          = '0;
                out_stb_addr_n = 1'b1;
                out_data_n     = addr24[23:16];
            end
            S_EMIT: begin
                if (cnt == CNT_W'(EMIT_LEN - 1)) begin
                    state_n    = S_WB;
                    wr_stb_n   = 1'b1;
                    wr_addr_n  = {ch, W_POS};
                    wr_data_n  = new_pos;
                    done_stb_n = step_done;
                    done_ch_n  = step_done ? ch : '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    case (cnt)
                        3'd0: begin
                            out_stb_addr_n = 1'b1;
                            out_data_n     = addr24[15:8];
                        end
                        3'd1: begin
                            out_stb_addr_n = 1'b1;
                            out_data_n     = addr24[7:0];
                        end
                        3'd2: begin
                            out_stb_mix_n = 1'b1;
                            out_data_n    = w_ctl.vol_l;
                        end
                        default: begin
                            out_stb_mix_n = 1'b1;
                            out_data_n    = w_ctl.vol_r;
                        end
                    endcase
                end
            end
            S_WB: begin
                if (ch == CH_AW'(NUM_CH - 1)) begin
                    frame_end = 1'b1;
                end else begin
                    ch_n    = ch + CH_AW'(1);
                    state_n = S_SCAN;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A sync landing on the final clk is a clean back-to-back start, not an overrun
        if (frame_end) begin
            ch_n = '0;
            if (pending || bus.sync_stb) begin
                state_n   = S_SCAN;
                ena_n     = bus.ch_enas;
                pending_n = 1'b0;
            end else begin
                state_n = S_IDLE;
            end
        end else if (state != S_IDLE && bus.sync_stb) begin
            pending_n = 1'b1;
            overrun_n = 1'b1;
        end

        busy_n = (state_n != S_IDLE);
    end

    assign bus.rd_addr      = rd_addr_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.wr_stb       = wr_stb_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_stb_addr = out_stb_addr_q;
    assign bus.out_stb_mix  = out_stb_mix_q;
    assign bus.done_stb     = done_stb_q;
    assign bus.done_ch      = done_ch_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_chan_seq.sv
// Directed bench for chan_seq: RAM model, expected-result queues filled by a
// behavioural channel model, compared as the DUT emits bytes, writes and dones.
module tb_chan_seq;
    localparam int unsigned NUM_CH = 32;
    localparam int unsigned FRAC   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chan_seq_if #(.NUM_CH(NUM_CH)) bus ();
    chan_seq #(.NUM_CH(NUM_CH), .ADDR_W(22)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [1:0] kind; logic [7:0] data; } out_t;
    typedef struct { logic [6:0] addr; logic [31:0] data; } wr_t;

    out_t        out_q[$];
    wr_t         wr_q[$];
    int          done_q[$];
    logic [31:0] mem [128];
    logic [31:0] mdl [128];
    logic [6:0]  addr_d = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          sb_en = 1'b1;
    int          wr_cnt = 0;
    int          busy_falls = 0;
    logic        busy_d = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel RAM: data for an address shows up one clk later; writes land on the strobe
    always @(negedge clk) begin
        bus.rd_data = mem[addr_d];
        addr_d = bus.rd_addr;
        if (bus.wr_stb) mem[bus.wr_addr] = bus.wr_data;
    end

    always @(negedge clk) begin
        out_t e;
        wr_t  w;
        int   d;
        if (bus.wr_stb) wr_cnt++;
        if (busy_d && !bus.busy) busy_falls++;
        busy_d = bus.busy;
        if (sb_en && !rst) begin
            if (bus.out_stb_addr || bus.out_stb_mix) begin
                check("out_avail", 64'(out_q.size() != 0), 64'd1);
                if (out_q.size() != 0) begin
                    e = out_q.pop_front();
                    check("out_kind", 64'({bus.out_stb_addr, bus.out_stb_mix}), 64'(e.kind));
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                end
            end else begin
                check("out_idle", 64'(bus.out_data), 64'd0);
            end
            if (bus.wr_stb) begin
                check("wr_avail", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(w.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(w.data));
                end
            end
            if (bus.done_stb) begin
                check("done_avail", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    check("done_ch", 64'(bus.done_ch), 64'(d));
                end
            end
        end
    end

    task automatic set_ch(input int c, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
        mem[c*4] = w0;   mem[c*4+1] = w1;   mem[c*4+2] = w2;   mem[c*4+3] = w3;
        mdl[c*4] = w0;   mdl[c*4+1] = w1;   mdl[c*4+2] = w2;   mdl[c*4+3] = w3;
    endtask

    task automatic expect_ch(input int c);
        logic [31:0] pos, ctl, endw, lp, a32, np, saddr;
        logic [63:0] s;
        bit          hit;
        pos  = mdl[c*4];
        ctl  = mdl[c*4+1];
        endw = mdl[c*4+2];
        lp   = mdl[c*4+3];
        a32  = pos >> FRAC;
        out_q.push_back('{2'b10, a32[23:16]});
        out_q.push_back('{2'b10, a32[15:8]});
        out_q.push_back('{2'b10, a32[7:0]});
        out_q.push_back('{2'b01, ctl[23:16]});
        out_q.push_back('{2'b01, ctl[31:24]});
        s     = 64'(pos) + 64'(ctl[15:0]);
        saddr = s[31:0] >> FRAC;
        hit   = s[32] || (saddr > 32'(endw[21:0]));
        np    = s[31:0];
        if (hit) begin
`ifdef CHAN_SEQ_LOOP_EN
            if (lp[31]) np = (32'(lp[21:0]) << FRAC) | (s[31:0] & 32'h3FF);
            else begin
                np = 32'(endw[21:0]) << FRAC;
                done_q.push_back(c);
            end
`else
            np = 32'(endw[21:0]) << FRAC;
            done_q.push_back(c);
`endif
        end
        mdl[c*4] = np;
        wr_q.push_back('{7'(c*4), np});
    endtask

    task automatic expect_frame(input logic [NUM_CH-1:0] en);
        for (int c = 0; c < NUM_CH; c++) if (en[c]) expect_ch(c);
    endtask

    task automatic pulse_sync();
        @(posedge clk); #1 bus.sync_stb = 1'b1;
        @(posedge clk); #1 bus.sync_stb = 1'b0;
    endtask

    // Counts busy clks of one frame started just before the call
    task automatic run_frame(input int bound, output int cyc);
        bit seen = 1'b0;
        bit fin  = 1'b0;
        cyc = 0;
        for (int i = 0; i < bound && !fin; i++) begin
            @(negedge clk);
            if (bus.busy) begin seen = 1'b1; cyc++; end
            else if (seen) fin = 1'b1;
        end
        check("frame_end", 64'(fin), 64'd1);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_out_left"},  64'(out_q.size()),  64'd0);
        check({tag, "_wr_left"},   64'(wr_q.size()),   64'd0);
        check({tag, "_done_left"}, 64'(done_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},    64'(bus.busy),         64'd0);
        check({tag, "_overrun"}, 64'(bus.overrun),      64'd0);
        check({tag, "_wr_stb"},  64'(bus.wr_stb),       64'd0);
        check({tag, "_stb_a"},   64'(bus.out_stb_addr), 64'd0);
        check({tag, "_stb_m"},   64'(bus.out_stb_mix),  64'd0);
        check({tag, "_done"},    64'(bus.done_stb),     64'd0);
        check({tag, "_data"},    64'(bus.out_data),     64'd0);
        check({tag, "_rd_addr"}, 64'(bus.rd_addr),      64'd0);
    endtask

    initial begin
        int cyc, base_falls, base_wr;
        bit found;
        bus.sync_stb = 1'b0;
        bus.ch_enas  = '0;
        bus.rd_data  = '0;
        for (int i = 0; i < 128; i++) begin mem[i] = '0; mdl[i] = '0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Single enabled channel, plain advance
        set_ch(5, 32'h0000_1000, 32'hB2A1_0400, 32'h100, 32'h0);
        bus.ch_enas = 32'h0000_0020;
        expect_frame(bus.ch_enas);
        pulse_sync();
        run_frame(200, cyc);
        check("t1_busy_clks", 64'(cyc), 64'd43);
        check("t1_mem_w0", 64'(mem[20]), 64'h1400);
        check_queues("t1");

        // Nothing enabled: scan only
        bus.ch_enas = '0;
        pulse_sync();
        run_frame(200, cyc);
        check("t2_busy_clks", 64'(cyc), 64'd32);
        check("t2_overrun", 64'(bus.overrun), 64'd0);

        // End reached with loop enable set
        set_ch(7, 32'h0004_0155, 32'h5566_0400, 32'h100, 32'h8000_0010);
        bus.ch_enas = 32'h0000_0080;
        expect_frame(bus.ch_enas);
        pulse_sync();
        run_frame(200, cyc);
        check("t3_busy_clks", 64'(cyc), 64'd43);
`ifdef CHAN_SEQ_LOOP_EN
        check("t3_mem_w0", 64'(mem[28]), 64'h4155);
`else
        check("t3_mem_w0", 64'(mem[28]), 64'h4_0000);
`endif
        check_queues("t3");

        // Carry out of the 32-bit add
        set_ch(9, 32'hFFFF_FFFF, 32'h1122_0001, 32'h2000, 32'h0);
        bus.ch_enas = 32'h0000_0200;
        expect_frame(bus.ch_enas);
        pulse_sync();
        run_frame(200, cyc);
        check("t6_mem_w0", 64'(mem[36]), 64'h80_0000);
        check_queues("t6");

        // All channels, sync every 300 clks: overlapping frames chain back-to-back
        for (int c = 0; c < NUM_CH; c++)
            set_ch(c, 32'(c) << 12, {8'(c), 8'(8'hFF - 8'(c)), 16'(16'h100 + c)}, 32'h3F_FFFF, 32'h0);
        bus.ch_enas = '1;
        repeat (4) expect_frame(bus.ch_enas);
        base_falls = busy_falls;
        base_wr    = wr_cnt;
        pulse_sync();
        repeat (298) @(posedge clk);
        pulse_sync();
        check("t4_overrun_set", 64'(bus.overrun), 64'd1);
        repeat (298) @(posedge clk);
        pulse_sync();
        repeat (298) @(posedge clk);
        pulse_sync();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!bus.busy) found = 1'b1;
        end
        check("t4_idle_reached", 64'(found), 64'd1);
        check("t4_busy_falls", 64'(busy_falls - base_falls), 64'd1);
        check("t4_wr_count", 64'(wr_cnt - base_wr), 64'd128);
        check("t4_overrun", 64'(bus.overrun), 64'd1);
        check_queues("t4");

        // Reset during EMIT of channel 3 aborts without a write-back
        sb_en = 1'b0;
        set_ch(3, 32'h0000_3000, 32'h4433_0100, 32'h100, 32'h0);
        bus.ch_enas = 32'h0000_0008;
        base_wr = wr_cnt;
        pulse_sync();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.out_stb_addr) found = 1'b1;
        end
        check("t5_emit_seen", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t5_rst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_wr", 64'(wr_cnt - base_wr), 64'd0);
        check("t5_idle", 64'(bus.busy), 64'd0);
        sb_en = 1'b1;
        set_ch(0, 32'h0000_2000, 32'h0C0B_0200, 32'h100, 32'h0);
        bus.ch_enas = 32'h0000_0009;
        expect_frame(bus.ch_enas);
        pulse_sync();
        run_frame(200, cyc);
        check("t5_busy_clks", 64'(cyc), 64'd54);
        check("t5_mem_ch0", 64'(mem[0]), 64'h2200);
        check("t5_mem_ch3", 64'(mem[12]), 64'h3100);
        check_queues("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
